// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-side load/store unit with bus timeout and misalignment detection
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  funct3,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [31:0] lat_addr, lat_wdata, cap_word;
  logic        lat_we, err_q;
  logic [3:0]  lat_wstrb;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_lo;

  logic        access, illegal, unaligned, start;
  logic [3:0]  strb_nxt;
  logic [31:0] wd_nxt;
  logic        stall_c, timeout_hit;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext_word;

  assign access    = rd_en | wr_en;
  assign illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                     (wr_en && funct3[2]);
  assign unaligned = ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
                     ((funct3[1:0] == 2'b01) && addr[0]);
  assign misalign  = access && (illegal || unaligned);
  assign start     = access && !illegal && !unaligned;

  // Store lanes: data replicated so the strobes alone pick the target bytes
  always_comb begin
    strb_nxt = 4'b0000;
    wd_nxt   = 32'h0;
    if (wr_en) begin
      case (funct3[1:0])
        2'b00: begin
          strb_nxt = 4'b0001 << addr[1:0];
          wd_nxt   = {4{wdata[7:0]}};
        end
        2'b01: begin
          strb_nxt = addr[1] ? 4'b1100 : 4'b0011;
          wd_nxt   = {2{wdata[15:0]}};
        end
        default: begin
          strb_nxt = 4'b1111;
          wd_nxt   = wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    stall_c     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall_c   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (bus_ready) begin
          state_nxt = DONE;
        end else if (cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      err_q     <= 1'b0;
      cap_word  <= 32'h0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_we    <= 1'b0;
      lat_wstrb <= 4'b0000;
      lat_f3    <= 3'b000;
      lat_lo    <= 2'b00;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        lat_addr  <= {addr[31:2], 2'b00};
        lat_wdata <= wd_nxt;
        lat_we    <= wr_en;
        lat_wstrb <= strb_nxt;
        lat_f3    <= funct3;
        lat_lo    <= addr[1:0];
        cnt       <= 8'd0;
      end
      if (state == REQ) begin
        if (bus_ready) begin
          cap_word <= bus_rdata;
          cnt      <= 8'd0;
        end else if (timeout_hit) begin
          cap_word <= 32'h0;
          err_q    <= 1'b1;
          cnt      <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  // Lane select uses the address captured at issue, not the live datapath address
  always_comb begin
    sel_byte = cap_word[7:0];
    case (lat_lo)
      2'b00: sel_byte = cap_word[7:0];
      2'b01: sel_byte = cap_word[15:8];
      2'b10: sel_byte = cap_word[23:16];
      2'b11: sel_byte = cap_word[31:24];
      default: sel_byte = cap_word[7:0];
    endcase
    sel_half = lat_lo[1] ? cap_word[31:16] : cap_word[15:0];
    case (lat_f3)
      3'b000:  ext_word = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  ext_word = {{16{sel_half[15]}}, sel_half};
      3'b010:  ext_word = cap_word;
      3'b100:  ext_word = {24'h0, sel_byte};
      3'b101:  ext_word = {16'h0, sel_half};
      default: ext_word = 32'h0;
    endcase
  end

  assign stall     = rst && stall_c;
  assign bus_valid = rst && (state == REQ);
  assign bus_we    = bus_valid && lat_we;
  assign bus_addr  = bus_valid ? lat_addr : 32'h0;
  assign bus_wstrb = bus_valid ? lat_wstrb : 4'b0000;
  assign bus_wdata = bus_valid ? lat_wdata : 32'h0;
  assign bus_err   = err_q;
  assign read_data = (rst && state == DONE) ? ext_word : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] read_data;
  logic        stall, misalign, bus_err, bus_valid, bus_we;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata = 32'h0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd_en(rd_en), .wr_en(wr_en),
    .funct3(funct3), .read_data(read_data), .stall(stall), .misalign(misalign),
    .bus_err(bus_err), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rd_exp_t;

  bus_exp_t bus_q[$];
  rd_exp_t  rd_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder: after `resp_waits` not-ready REQ cycles, assert ready with resp_rdata
  int          resp_waits = 0;
  logic [31:0] resp_rdata = 32'h0;
  int          wcnt = 0;
  always @(posedge clk) begin
    #2;
    if (bus_valid && wcnt >= resp_waits) begin
      bus_ready = 1'b1;
      bus_rdata = resp_rdata;
    end else begin
      bus_ready = 1'b0;
      bus_rdata = 32'hBAD0BAD0;
      if (bus_valid) wcnt++;
      else wcnt = 0;
    end
  end

  // Monitor: bus handshakes and access completions are checked against the queues
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst && bus_valid && bus_ready) begin
      if (bus_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL bus_unexpected: got handshake at %h expected none", bus_addr);
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        check("bus_addr", bus_addr, e.addr);
        check("bus_we", 32'(bus_we), 32'(e.we));
        check("bus_wstrb", 32'(bus_wstrb), 32'(e.strb));
        check("bus_wdata", bus_wdata, e.wdata);
      end
    end
    if (rst && prev_stall && !stall && (rd_en || wr_en)) begin
      if (rd_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rd_unexpected: got completion %h expected none", read_data);
      end else begin
        rd_exp_t r;
        r = rd_q.pop_front();
        check("read_data", read_data, r.rdata);
        check("bus_err", 32'(bus_err), 32'(r.err));
      end
    end
    prev_stall = stall;
  end

  task automatic do_access(input string name, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input int waits, input logic [31:0] rdw,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                           input bit timeout);
    int nst;
    int nv;
    bus_exp_t be;
    rd_exp_t  re;
    if (!timeout) begin
      be.addr  = {a[31:2], 2'b00};
      be.we    = wr;
      be.strb  = exp_strb;
      be.wdata = exp_wd;
      bus_q.push_back(be);
    end
    re.rdata = exp_rd;
    re.err   = exp_err;
    rd_q.push_back(re);
    resp_waits = waits;
    resp_rdata = rdw;
    @(posedge clk);
    #1;
    rd_en = rd; wr_en = wr; funct3 = f3; addr = a; wdata = wd;
    nst = 0;
    nv  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_valid) nv++;
      if (!stall) break;
      nst++;
    end
    check({name, "_stall_cycles"}, 32'(nst), timeout ? 32'(1 + TO) : 32'(2 + waits));
    check({name, "_req_cycles"}, 32'(nv), timeout ? 32'(TO) : 32'(1 + waits));
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic do_bad(input string name, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a);
    @(posedge clk);
    #1;
    rd_en = rd; wr_en = wr; funct3 = f3; addr = a; wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({name, "_misalign"}, 32'(misalign), 32'd1);
      check({name, "_stall"}, 32'(stall), 32'd0);
      check({name, "_valid"}, 32'(bus_valid), 32'd0);
    end
    check({name, "_read_data"}, read_data, 32'h0);
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with a load present
    rst = 1'b0; rd_en = 1'b1; funct3 = 3'b010; addr = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_valid", 32'(bus_valid), 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check("rst_read_data", read_data, 32'h0);
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0; rst = 1'b1;

    // stores
    do_access("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 0);
    do_access("sb", 0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 32'h0, 32'h0, 0, 4'b1000, 32'hA5A5A5A5, 0);
    do_access("sh", 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 2, 32'h0, 32'h0, 0, 4'b1100, 32'hABCDABCD, 0);
    do_access("sb_both", 1, 1, 3'b000, 32'h300, 32'h0000005A, 0, 32'h0, 32'h0, 0, 4'b0001, 32'h5A5A5A5A, 0);

    // loads
    do_access("lb", 1, 0, 3'b000, 32'h1, 32'h0, 0, 32'h000080FF, 32'hFFFFFF80, 0, 4'b0000, 32'h0, 0);
    do_access("lbu", 1, 0, 3'b100, 32'h1, 32'h0, 0, 32'h000080FF, 32'h00000080, 0, 4'b0000, 32'h0, 0);
    do_access("lh", 1, 0, 3'b001, 32'h2, 32'h0, 0, 32'h80010000, 32'hFFFF8001, 0, 4'b0000, 32'h0, 0);
    do_access("lhu", 1, 0, 3'b101, 32'h2, 32'h0, 1, 32'h80010000, 32'h00008001, 0, 4'b0000, 32'h0, 0);
    do_access("lw", 1, 0, 3'b010, 32'h104, 32'h0, 1, 32'h12345678, 32'h12345678, 0, 4'b0000, 32'h0, 0);
    do_access("lb3", 1, 0, 3'b000, 32'h3, 32'h0, 0, 32'h7F000000, 32'h0000007F, 0, 4'b0000, 32'h0, 0);

    // misaligned and illegal accesses
    do_bad("lw_mis", 1, 0, 3'b010, 32'h102);
    do_bad("f3_011", 1, 0, 3'b011, 32'h100);
    do_bad("sh_mis", 0, 1, 3'b001, 32'h101);
    do_bad("st_f3_100", 0, 1, 3'b100, 32'h100);

    // reset in the middle of REQ abandons the access
    resp_waits = 255;
    @(posedge clk);
    #1;
    rd_en = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    @(negedge clk);
    check("midreq_valid", 32'(bus_valid), 32'd1);
    rst = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("midreq_rst_valid", 32'(bus_valid), 32'd0);
    check("midreq_rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midreq_after_valid", 32'(bus_valid), 32'd0);

    // timeout, then sticky error across a good access
    do_access("lw_to", 1, 0, 3'b010, 32'h200, 32'h0, 255, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 1);
    do_access("lw_sticky", 1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h11223344, 32'h11223344, 1, 4'b0000, 32'h0, 0);
    @(negedge clk);
    check("err_sticky_idle", 32'(bus_err), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("err_cleared", 32'(bus_err), 32'd0);

    repeat (2) @(negedge clk);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
